// File: rtl/keccak_pkg.sv
// keccak_pkg: shared widths and absorb FSM states for the Keccak absorb path
package keccak_pkg;
  localparam int LANE_WIDTH     = 64;
  localparam int MAX_RATE_LANES = 21;
  localparam int LANE_IDX_WIDTH = 5;
  localparam int KEEP_WIDTH     = 4;
  localparam int RATE_WIDTH     = 11;
  localparam int SUFFIX_WIDTH   = 8;
  typedef enum logic [1:0] {IDLE, ABSORB, PAD} absorb_state_e;
endpackage

// File: rtl/keccak_pad_lane_gen.sv
// keccak_pad_lane_gen: masks bytes at/above keep, ORs in the domain suffix and the closing 0x80 pad bit
module keccak_pad_lane_gen
  import keccak_pkg::*;
(
  input  logic [LANE_WIDTH-1:0]   data_i,
  input  logic [KEEP_WIDTH-1:0]   keep_i,
  input  logic [SUFFIX_WIDTH-1:0] suffix_i,
  input  logic                    suffix_en_i,
  input  logic                    pad_end_i,
  output logic [LANE_WIDTH-1:0]   lane_o
);
  // byte b survives when b<keep; the first dropped byte carries the suffix; bit 63 closes pad10*1
  always_comb begin
    lane_o = '0;
    for (int b = 0; b < 8; b++)
      lane_o[8*b +: 8] = (KEEP_WIDTH'(b) < keep_i) ? data_i[8*b +: 8] :
                         (suffix_en_i && KEEP_WIDTH'(b) == keep_i) ? suffix_i : 8'h00;
    lane_o[LANE_WIDTH-1] = lane_o[LANE_WIDTH-1] | pad_end_i;
  end
endmodule

// File: rtl/keccak_absorb_padder.sv
// keccak_absorb_padder: turns a 64-bit message stream into pad10*1-padded rate blocks, one lane per cycle
module keccak_absorb_padder
  import keccak_pkg::*;
#(
  parameter int LANE_W    = LANE_WIDTH,
  parameter int MAX_LANES = MAX_RATE_LANES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [RATE_WIDTH-1:0]        rate_i,
  input  logic [SUFFIX_WIDTH-1:0]      suffix_i,
  input  logic [LANE_W-1:0]            t_data_i,
  input  logic [KEEP_WIDTH-1:0]        t_keep_i,
  input  logic                         t_last_i,
  input  logic                         t_valid_i,
  output logic                         t_ready_o,
  output logic [LANE_W-1:0]            lane_o,
  output logic [$clog2(MAX_LANES)-1:0] lane_idx_o,
  output logic                         lane_valid_o,
  input  logic                         lane_ready_i,
  output logic                         block_last_o,
  output logic                         msg_last_o,
  output logic                         busy_o
);
  absorb_state_e state_q;
  logic [RATE_WIDTH-1:0]     rate_q;
  logic [SUFFIX_WIDTH-1:0]   suffix_q;
  logic [LANE_IDX_WIDTH-1:0] idx_q;
  logic                      pend_q;
  logic                      busy_q;
  logic [LANE_WIDTH-1:0]     lane_q;
  logic [LANE_IDX_WIDTH-1:0] lane_idx_q;
  logic                      lane_valid_q;
  logic                      block_last_q;
  logic                      msg_last_q;
  logic [LANE_IDX_WIDTH-1:0] last_idx;
  logic                      at_end;
  logic                      adv;
  logic                      full_w;
  logic                      in_fire;
  logic                      fin_pending;
  logic                      fin_hs;
  logic                      pad_fire;
  logic                      in_pad;
  logic [LANE_WIDTH-1:0]     gen_lane;
  assign last_idx    = LANE_IDX_WIDTH'((rate_q >> 6) - RATE_WIDTH'(1));
  assign at_end      = idx_q == last_idx;
  assign adv         = !lane_valid_q || lane_ready_i;
  assign in_pad      = state_q == PAD;
  assign t_ready_o   = (state_q == ABSORB) && adv;
  assign in_fire     = t_valid_i && t_ready_o;
  assign full_w      = !t_last_i || (t_keep_i >= KEEP_WIDTH'(8));
  assign fin_pending = lane_valid_q && block_last_q && msg_last_q;
  assign fin_hs      = fin_pending && lane_ready_i;
  assign pad_fire    = in_pad && adv && !fin_pending;
  keccak_pad_lane_gen u_gen (
    .data_i      (in_pad ? '0 : t_data_i),
    .keep_i      (in_pad ? KEEP_WIDTH'(0) : (full_w ? KEEP_WIDTH'(8) : t_keep_i)),
    .suffix_i    (suffix_q),
    .suffix_en_i (in_pad ? pend_q : !full_w),
    .pad_end_i   (at_end && (in_pad || !full_w)),
    .lane_o      (gen_lane)
  );
  // absorb FSM, lane counter and the single output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rate_q       <= '0;
      suffix_q     <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      busy_q       <= 1'b0;
      lane_q       <= '0;
      lane_idx_q   <= '0;
      lane_valid_q <= 1'b0;
      block_last_q <= 1'b0;
      msg_last_q   <= 1'b0;
    end else begin
      if (lane_valid_q && lane_ready_i) lane_valid_q <= 1'b0;
      if (in_fire || pad_fire) begin
        lane_q       <= gen_lane;
        lane_idx_q   <= idx_q;
        lane_valid_q <= 1'b1;
        block_last_q <= at_end;
        msg_last_q   <= in_pad || (t_last_i && !(full_w && at_end));
        idx_q        <= at_end ? '0 : idx_q + 1'b1;
      end
      if (fin_hs) busy_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i && !busy_q) begin
          state_q  <= ABSORB;
          busy_q   <= 1'b1;
          rate_q   <= rate_i;
          suffix_q <= suffix_i;
          idx_q    <= '0;
          pend_q   <= 1'b0;
        end
        ABSORB: if (in_fire && t_last_i) begin
          state_q <= (!full_w && at_end) ? IDLE : PAD;
          pend_q  <= full_w;
        end
        PAD: begin
          if (pad_fire) pend_q <= 1'b0;
          if (fin_hs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign lane_o       = lane_q;
  assign lane_idx_o   = lane_idx_q;
  assign lane_valid_o = lane_valid_q;
  assign block_last_o = block_last_q;
  assign msg_last_o   = msg_last_q;
  assign busy_o       = busy_q;
endmodule

// File: tb/tb_keccak_absorb_padder.sv
// tb_keccak_absorb_padder: directed padding scenarios with hand-computed lanes and a stall-equivalence run
module tb_keccak_absorb_padder;
  import keccak_pkg::*;
  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start_i = 1'b0;
  logic [RATE_WIDTH-1:0]   rate_i = '0;
  logic [SUFFIX_WIDTH-1:0] suffix_i = '0;
  logic [63:0]             t_data_i = '0;
  logic [3:0]              t_keep_i = '0;
  logic                    t_last_i = 1'b0;
  logic                    t_valid_i = 1'b0;
  logic                    t_ready_o;
  logic [63:0]             lane_o;
  logic [4:0]              lane_idx_o;
  logic                    lane_valid_o;
  logic                    lane_ready_i = 1'b1;
  logic                    block_last_o;
  logic                    msg_last_o;
  logic                    busy_o;
  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  i;
    logic        bl;
    logic        ml;
  } rec_t;
  rec_t q[$];
  rec_t e_ref[$];
  rec_t s_ref[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   stall = 1'b0;
  keccak_absorb_padder dut (
    .clk(clk), .rst(rst), .start_i(start_i), .rate_i(rate_i), .suffix_i(suffix_i),
    .t_data_i(t_data_i), .t_keep_i(t_keep_i), .t_last_i(t_last_i), .t_valid_i(t_valid_i),
    .t_ready_o(t_ready_o), .lane_o(lane_o), .lane_idx_o(lane_idx_o), .lane_valid_o(lane_valid_o),
    .lane_ready_i(lane_ready_i), .block_last_o(block_last_o), .msg_last_o(msg_last_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] wd(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction
  function automatic rec_t at(input int i);
    return (i < q.size()) ? q[i] : '0;
  endfunction
  // downstream: choose ready at negedge, record lanes that will handshake at the next posedge
  always @(negedge clk) begin
    lane_ready_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    #1;
    if (lane_valid_o && lane_ready_i) q.push_back('{lane_o, lane_idx_o, block_last_o, msg_last_o});
    if (lane_valid_o && !lane_ready_i) check("stall_t_ready", 64'(t_ready_o), 64'd0);
  end
  task automatic begin_msg(input int rate, input logic [7:0] sfx);
    q.delete();
    rate_i = RATE_WIDTH'(rate);
    suffix_i = sfx;
    start_i = 1'b1;
    @(negedge clk);
    #1;
    start_i = 1'b0;
    check("busy_set", 64'(busy_o), 64'd1);
  endtask
  task automatic send(input logic [63:0] d, input logic [3:0] k, input logic l);
    int  cyc = 0;
    bit  ok;
    t_data_i = d;
    t_keep_i = k;
    t_last_i = l;
    t_valid_i = 1'b1;
    do begin
      ok = t_ready_o;
      @(negedge clk);
      #1;
      cyc++;
    end while (!ok && cyc < 300);
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    t_valid_i = 1'b0;
    t_last_i = 1'b0;
  endtask
  task automatic finish_msg();
    int c = 0;
    while (busy_o && c < 3000) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("busy_done", 64'(busy_o), 64'd0);
  endtask
  task automatic cmp_q(input string tag, input rec_t a[$], input rec_t b[$]);
    int d = 0;
    check({tag, "_cnt"}, 64'(a.size()), 64'(b.size()));
    foreach (a[i]) if (i >= b.size() || a[i] !== b[i]) d++;
    check({tag, "_diff"}, 64'(d), 64'd0);
  endtask
  task automatic empty_msg();
    begin_msg(1088, 8'h06);
    send(64'hDEAD_BEEF_DEAD_BEEF, 4'd0, 1'b1);
    finish_msg();
  endtask
  task automatic shake256_msg();
    begin_msg(1088, 8'h1F);
    for (int i = 0; i < 40; i++) send(wd(i), (i == 39) ? 4'd5 : 4'd8, i == 39);
    finish_msg();
  endtask
  initial begin
    logic [63:0] acc;
    int          nbl;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 64'(lane_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_tready", 64'(t_ready_o), 64'd0);
    check("rst_lane", lane_o, 64'd0);
    check("rst_flags", {62'd0, block_last_o, msg_last_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    empty_msg();
    e_ref = q;
    check("e_cnt", 64'(q.size()), 64'd17);
    check("e_l0", at(0).d, 64'h06);
    acc = '0;
    nbl = 0;
    for (int i = 1; i < 16; i++) acc |= at(i).d;
    foreach (q[i]) nbl += int'(q[i].bl);
    check("e_mid_zero", acc, 64'd0);
    check("e_l16", at(16).d, 64'h8000_0000_0000_0000);
    check("e_l16_idx", 64'(at(16).i), 64'd16);
    check("e_l16_flags", {62'd0, at(16).bl, at(16).ml}, 64'd3);
    check("e_nbl", 64'(nbl), 64'd1);
    begin_msg(1088, 8'h06);
    send(wd(0), 4'd8, 1'b0);
    send(wd(1), 4'd8, 1'b0);
    send(64'h1122_3344_5566_7788, 4'd3, 1'b1);
    finish_msg();
    check("k3_cnt", 64'(q.size()), 64'd17);
    check("k3_l1", at(1).d, wd(1));
    check("k3_l2", at(2).d, 64'h0000_0000_0666_7788);
    check("k3_l16", at(16).d, 64'h8000_0000_0000_0000);
    check("k3_l16_flags", {62'd0, at(16).bl, at(16).ml}, 64'd3);
    begin_msg(576, 8'h06);
    for (int i = 0; i < 8; i++) send(wd(i), 4'd8, 1'b0);
    send(64'hA1B2_C3D4_E5F6_0718, 4'd7, 1'b1);
    finish_msg();
    check("s512_cnt", 64'(q.size()), 64'd9);
    check("s512_l8", at(8).d, 64'h86B2_C3D4_E5F6_0718);
    check("s512_l8_idx", 64'(at(8).i), 64'd8);
    check("s512_l8_flags", {62'd0, at(8).bl, at(8).ml}, 64'd3);
    check("s512_l7_bl", 64'(at(7).bl), 64'd0);
    begin_msg(1344, 8'h1F);
    for (int i = 0; i < 21; i++) send(wd(i), 4'd8, i == 20);
    finish_msg();
    check("sh128_cnt", 64'(q.size()), 64'd42);
    check("sh128_l20", at(20).d, wd(20));
    check("sh128_l20_flags", {62'd0, at(20).bl, at(20).ml}, 64'd2);
    check("sh128_b2l0", at(21).d, 64'h1F);
    check("sh128_b2l0_idx", 64'(at(21).i), 64'd0);
    check("sh128_b2l19", at(40).d, 64'd0);
    check("sh128_b2l20", at(41).d, 64'h8000_0000_0000_0000);
    check("sh128_b2l20_flags", {62'd0, at(41).bl, at(41).ml}, 64'd3);
    shake256_msg();
    s_ref = q;
    check("sh256_cnt", 64'(q.size()), 64'd51);
    check("sh256_l39", at(39).d, 64'h0000_1F00_0000_0027);
    check("sh256_l50", at(50).d, 64'h8000_0000_0000_0000);
    check("sh256_l50_flags", {62'd0, at(50).bl, at(50).ml}, 64'd3);
    stall = 1'b1;
    shake256_msg();
    stall = 1'b0;
    cmp_q("stall", q, s_ref);
    begin_msg(1088, 8'h06);
    for (int i = 0; i < 5; i++) send(wd(i), 4'd8, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_valid", 64'(lane_valid_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_lane", lane_o, 64'd0);
    check("mid_rst_idx", 64'(lane_idx_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    empty_msg();
    cmp_q("post_rst", q, e_ref);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
